safecrack_btn_arbiter: RTL and testbench

Input front-end and arbiter for the safecrack lock FSM. It synchronises and debounces the three active-low raw buttons and arbitrates between them so that the lock FSM sees at most one accepted press per physical press. Each press is offered over a valid/ready handshake. Simultaneous presses are rejected as a conflict instead of being passed on as a multi-hot code.

---
 rtl/safecrack_btn_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_safecrack_btn_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/safecrack_btn_arbiter.sv
// safecrack_btn_arbiter: synchroniser, debouncer and single-press arbiter for
// the three active-low safecrack buttons. Each debounced press is offered to
// the lock FSM over a valid/ready handshake. Simultaneous presses are reported
// as a conflict pulse and are not offered.
// Optional build macro: SAFECRACK_ARB_TIMEOUT_EN. When it is defined, an offer
// that is not accepted within TIMEOUT_CYCLES is dropped and the timeout output
// pulses.
module safecrack_btn_arbiter #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMEOUT_CYCLES  = 250_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn,
   output logic       press_valid,
   output logic [2:0] press_onehot,
   input  logic       press_ready,
   output logic       conflict,
   output logic       timeout
);

   localparam int            DW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);

   // Reject configurations the debouncer and timeout counter cannot handle.
   if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_err
      $error("safecrack_btn_arbiter: need DEBOUNCE_CYCLES >= 2 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE         = 3'b001,
      ST_OFFER        = 3'b010,
      ST_WAIT_RELEASE = 3'b100
   } state_t;

   // True when two or more of the three bits are set.
   function automatic logic multi_hot(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   logic [2:0]    sync1_r;
   logic [2:0]    sync2_r;
   logic [2:0]    pressed_s;
   logic [2:0]    stable_r;
   logic [2:0]    stable_prev_r;
   logic [2:0]    edge_r;
   logic [DW-1:0] db_cnt_r [3];

   state_t        state_r;
   state_t        state_s;
   logic          press_valid_r;
   logic          press_valid_s;
   logic [2:0]    press_onehot_r;
   logic [2:0]    press_onehot_s;
   logic          conflict_r;
   logic          conflict_s;

   // Two-flop synchroniser; released (1) on reset so no phantom press appears.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 3'b111;
         sync2_r <= 3'b111;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = ~sync2_r;

   // Per-button debounce: a level must differ for DEBOUNCE_CYCLES cycles to be taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable_r <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            db_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (pressed_s[i] == stable_r[i]) begin
               db_cnt_r[i] <= '0;
            end else if (db_cnt_r[i] == DB_LAST) begin
               stable_r[i] <= pressed_s[i];
               db_cnt_r[i] <= '0;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
            end
         end
      end
   end

   // Registered rising-edge detect on the debounced, active-high levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable_prev_r <= 3'b000;
         edge_r        <= 3'b000;
      end else begin
         stable_prev_r <= stable_r;
         edge_r        <= stable_r & ~stable_prev_r;
      end
   end

`ifdef SAFECRACK_ARB_TIMEOUT_EN
   localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   logic [TW-1:0] tmo_cnt_r;
   logic [TW-1:0] tmo_cnt_s;
   logic          timeout_r;
   logic          timeout_s;

   // Arbiter next state and next outputs; a handshake beats an expiring timeout.
   always_comb begin
      state_s        = state_r;
      press_valid_s  = press_valid_r;
      press_onehot_s = press_onehot_r;
      conflict_s     = 1'b0;
      timeout_s      = 1'b0;
      tmo_cnt_s      = tmo_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (multi_hot(edge_r)) begin
               conflict_s = 1'b1;
               state_s    = ST_WAIT_RELEASE;
            end else if (edge_r != 3'b000) begin
               press_valid_s  = 1'b1;
               press_onehot_s = edge_r;
               tmo_cnt_s      = '0;
               state_s        = ST_OFFER;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (press_valid_r && press_ready) begin
               press_valid_s  = 1'b0;
               press_onehot_s = 3'b000;
               state_s        = ST_WAIT_RELEASE;
            end else if (tmo_cnt_r == TMO_LAST) begin
               press_valid_s  = 1'b0;
               press_onehot_s = 3'b000;
               timeout_s      = 1'b1;
               state_s        = ST_WAIT_RELEASE;
            end else begin
               tmo_cnt_s = tmo_cnt_r + TMO_ONE;
            end
         end
         ST_WAIT_RELEASE: begin
            if (stable_r == 3'b000) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT_RELEASE;
            end
         end
         default: begin
            state_s        = ST_IDLE;
            press_valid_s  = 1'b0;
            press_onehot_s = 3'b000;
         end
      endcase
   end

   // Offer timeout counter and the registered timeout pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= '0;
         timeout_r <= 1'b0;
      end else begin
         tmo_cnt_r <= tmo_cnt_s;
         timeout_r <= timeout_s;
      end
   end

   assign timeout = timeout_r;
`else
   // Arbiter next state and next outputs; an offer is held until accepted.
   always_comb begin
      state_s        = state_r;
      press_valid_s  = press_valid_r;
      press_onehot_s = press_onehot_r;
      conflict_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (multi_hot(edge_r)) begin
               conflict_s = 1'b1;
               state_s    = ST_WAIT_RELEASE;
            end else if (edge_r != 3'b000) begin
               press_valid_s  = 1'b1;
               press_onehot_s = edge_r;
               state_s        = ST_OFFER;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (press_valid_r && press_ready) begin
               press_valid_s  = 1'b0;
               press_onehot_s = 3'b000;
               state_s        = ST_WAIT_RELEASE;
            end else begin
               state_s = ST_OFFER;
            end
         end
         ST_WAIT_RELEASE: begin
            if (stable_r == 3'b000) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT_RELEASE;
            end
         end
         default: begin
            state_s        = ST_IDLE;
            press_valid_s  = 1'b0;
            press_onehot_s = 3'b000;
         end
      endcase
   end

   assign timeout = 1'b0;
`endif

   // Arbiter state and registered handshake/conflict outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         press_valid_r  <= 1'b0;
         press_onehot_r <= 3'b000;
         conflict_r     <= 1'b0;
      end else begin
         state_r        <= state_s;
         press_valid_r  <= press_valid_s;
         press_onehot_r <= press_onehot_s;
         conflict_r     <= conflict_s;
      end
   end

   assign press_valid  = press_valid_r;
   assign press_onehot = press_onehot_r;
   assign conflict     = conflict_r;

endmodule

// File: tb/tb_safecrack_btn_arbiter.sv
// Scoreboard bench for safecrack_btn_arbiter with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8.
// Stimulus pushes expected output events (kind, id, start cycle, length);
// a negedge monitor rebuilds events from the DUT outputs and compares them.
module tb_safecrack_btn_arbiter;

   localparam int K_PRESS    = 0;
   localparam int K_CONFLICT = 1;
   localparam int K_TIMEOUT  = 2;

   typedef struct {
      int         kind;
      logic [2:0] oh;
      int         start;
      int         len;
   } ev_t;

   logic       clk          = 1'b0;
   logic       rst          = 1'b1;
   logic [2:0] btn          = 3'b111;
   logic       press_ready  = 1'b0;
   logic       press_valid;
   logic [2:0] press_onehot;
   logic       conflict;
   logic       timeout;

   ev_t expq[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;

   bit         v_on = 1'b0;
   bit         c_on = 1'b0;
   bit         t_on = 1'b0;
   int         v_start;
   int         c_start;
   int         t_start;
   logic [2:0] v_oh;

   safecrack_btn_arbiter #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .press_valid (press_valid),
      .press_onehot(press_onehot),
      .press_ready (press_ready),
      .conflict    (conflict),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input int kind, input logic [2:0] oh, input int start, input int len);
      ev_t e;
      e.kind  = kind;
      e.oh    = oh;
      e.start = start;
      e.len   = len;
      expq.push_back(e);
   endtask

   task automatic emit(input int kind, input logic [2:0] oh, input int start, input int len);
      ev_t e;
      vectors++;
      if (expq.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: got kind=%0d oh=%b start=%0d len=%0d, required no event",
                  kind, oh, start, len);
      end else begin
         e = expq.pop_front();
         if (e.kind != kind || e.oh != oh || e.start != start || e.len != len) begin
            miscompares++;
            $display("FAIL event: got kind=%0d oh=%b start=%0d len=%0d, required kind=%0d oh=%b start=%0d len=%0d",
                     kind, oh, start, len, e.kind, e.oh, e.start, e.len);
         end
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Monitor: per-cycle invariants, and event reconstruction from output runs.
   always @(negedge clk) begin
      vectors++;
      if ($isunknown({press_valid, press_onehot, conflict, timeout}) ||
          (press_valid && conflict) ||
          (!press_valid && press_onehot != 3'b000) ||
          (v_on && press_valid && press_onehot != v_oh)) begin
         miscompares++;
         $display("FAIL invariant: cycle %0d got valid=%b oh=%b conflict=%b timeout=%b",
                  cyc, press_valid, press_onehot, conflict, timeout);
      end
      if (press_valid === 1'b1 && !v_on) begin
         v_on    = 1'b1;
         v_start = cyc;
         v_oh    = press_onehot;
      end else if (press_valid !== 1'b1 && v_on) begin
         v_on = 1'b0;
         emit(K_PRESS, v_oh, v_start, cyc - v_start);
      end
      if (conflict === 1'b1 && !c_on) begin
         c_on    = 1'b1;
         c_start = cyc;
      end else if (conflict !== 1'b1 && c_on) begin
         c_on = 1'b0;
         emit(K_CONFLICT, 3'b000, c_start, cyc - c_start);
      end
      if (timeout === 1'b1 && !t_on) begin
         t_on    = 1'b1;
         t_start = cyc;
      end else if (timeout !== 1'b1 && t_on) begin
         t_on = 1'b0;
         emit(K_TIMEOUT, 3'b000, t_start, cyc - t_start);
      end
   end

   initial begin
      int c;

      // 1. Reset state, then quiet after reset with buttons released.
      rst         = 1'b1;
      btn         = 3'b111;
      press_ready = 1'b0;
      step(2);
      check_bit("reset_valid",    press_valid,     1'b0);
      check_bit("reset_oh0",      press_onehot[0], 1'b0);
      check_bit("reset_oh1",      press_onehot[1], 1'b0);
      check_bit("reset_oh2",      press_onehot[2], 1'b0);
      check_bit("reset_conflict", conflict,        1'b0);
      check_bit("reset_timeout",  timeout,         1'b0);
      rst = 1'b0;
      step(50);

      // 2. Clean press of btn[0], long hold, then btn[1].
      press_ready = 1'b1;
      c = cyc;
      btn = 3'b110;
      expect_ev(K_PRESS, 3'b001, c + 8, 1);
      step(100);
      btn = 3'b111;
      step(20);
      c = cyc;
      btn = 3'b101;
      expect_ev(K_PRESS, 3'b010, c + 8, 1);
      step(20);
      btn = 3'b111;
      step(20);

      // 3. Bounce on btn[2] with low periods of 1..3 cycles.
      for (int i = 0; i < 8; i++) begin
         btn = 3'b011;
         step((i % 3) + 1);
         btn = 3'b111;
         step(2);
      end
      step(20);

`ifndef SAFECRACK_ARB_TIMEOUT_EN
      // 4. Backpressure: offer held 21 cycles, second button ignored.
      press_ready = 1'b0;
      c = cyc;
      btn = 3'b110;
      expect_ev(K_PRESS, 3'b001, c + 8, 21);
      step(10);
      btn = 3'b100;
      step(18);
      press_ready = 1'b1;
      step(1);
      press_ready = 1'b0;
      btn = 3'b111;
      step(20);
`endif

      // 5. Conflict on two simultaneous presses, then a normal btn[2] press.
      press_ready = 1'b1;
      c = cyc;
      btn = 3'b100;
      expect_ev(K_CONFLICT, 3'b000, c + 8, 1);
      step(20);
      btn = 3'b111;
      step(20);
      c = cyc;
      btn = 3'b011;
      expect_ev(K_PRESS, 3'b100, c + 8, 1);
      step(20);
      btn = 3'b111;
      step(20);

`ifdef SAFECRACK_ARB_TIMEOUT_EN
      // 6. Timeout after 8 cycles of offer, then reset in the middle of an offer.
      press_ready = 1'b0;
      c = cyc;
      btn = 3'b101;
      expect_ev(K_PRESS,   3'b010, c + 8,  8);
      expect_ev(K_TIMEOUT, 3'b000, c + 16, 1);
      step(40);
      btn = 3'b111;
      step(20);
      c = cyc;
      btn = 3'b101;
      expect_ev(K_PRESS, 3'b010, c + 8, 4);
      step(11);
      rst = 1'b1;
      btn = 3'b111;
      step(1);
      rst = 1'b0;
      step(20);
`endif

      step(10);
      vectors++;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL pending_events: got %0d events never seen, required 0", expq.size());
      end
      check_bit("final_valid", press_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
